// File: rtl/sid_pkg.sv
// Shared constants, register map and sequencer state type for the SID filter front-end.
package sid_pkg;

  localparam int unsigned CLK_DIV_DEF     = 32;
  localparam int unsigned FILT_CYCLES_DEF = 12;

  localparam logic [4:0] ADDR_FC_LO    = 5'h15;
  localparam logic [4:0] ADDR_FC_HI    = 5'h16;
  localparam logic [4:0] ADDR_RES_FILT = 5'h17;
  localparam logic [4:0] ADDR_MODE_VOL = 5'h18;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_BUSY    = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [7:0] mode_vol;
    logic [7:0] res_filt;
    logic [7:0] fc_hi;
    logic [7:0] fc_lo;
  } filt_regs_t;

endpackage

// File: rtl/sid_tick_div.sv
// Free-running sample divider with a registered internal/external tick source select.
module sid_tick_div #(
  parameter int unsigned CLK_DIV = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic ext_tick,
  input  logic use_ext_tick,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             use_ext_q;

  // Mode select is registered so a mid-run switch lands cleanly on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      use_ext_q <= 1'b0;
    end else begin
      cnt_q     <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      use_ext_q <= use_ext_tick;
    end
  end

  assign tick_c = use_ext_q ? ext_tick : (cnt_q == CNT_MAX);

endmodule

// File: rtl/sid_filter_seq.sv
// Sample-rate sequencer and shadowed register front-end feeding the SID filter datapath.
module sid_filter_seq
  import sid_pkg::*;
#(
  parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
  parameter int unsigned FILT_CYCLES = FILT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_tick,
  input  logic        use_ext_tick,
  input  logic        bus_we,
  input  logic [4:0]  bus_addr,
  input  logic [7:0]  bus_data,
  input  logic [11:0] voice1_i,
  input  logic [11:0] voice2_i,
  input  logic [11:0] voice3_i,
  input  logic [11:0] ext_in_i,
  input  logic        extfilt_i,
  input  logic [17:0] sound_in,
  output logic [7:0]  Fc_lo,
  output logic [7:0]  Fc_hi,
  output logic [7:0]  Res_Filt,
  output logic [7:0]  Mode_Vol,
  output logic [11:0] voice1_o,
  output logic [11:0] voice2_o,
  output logic [11:0] voice3_o,
  output logic [11:0] ext_o,
  output logic        extfilter_en,
  output logic        input_valid,
  output logic [17:0] sound_out,
  output logic        sound_valid,
  output logic        overrun,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned BUSY_W = $clog2(FILT_CYCLES + 1);
  localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(FILT_CYCLES - 2);

  logic              tick_c;
  seq_state_e        state_q, state_d;
  logic [BUSY_W-1:0] busy_q, busy_d;
  logic              commit, capture, drop;
  logic              primed_q;
  filt_regs_t        pend_q, act_q;

  sid_tick_div #(.CLK_DIV(CLK_DIV)) u_tick_div (
    .clk          (clk),
    .rst          (rst),
    .ext_tick     (ext_tick),
    .use_ext_tick (use_ext_tick),
    .tick_c       (tick_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; a tick outside IDLE is never queued
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    commit  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick_c) begin
          commit  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        busy_d  = BUSY_LOAD;
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (busy_q == '0) state_d = ST_IDLE;
        else              busy_d  = busy_q - BUSY_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    drop = tick_c && (state_q != ST_IDLE);
  end

  // Shadow/active registers, operand latches, capture and overrun tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= '0;
      act_q        <= '0;
      voice1_o     <= '0;
      voice2_o     <= '0;
      voice3_o     <= '0;
      ext_o        <= '0;
      extfilter_en <= 1'b0;
      input_valid  <= 1'b0;
      sound_out    <= '0;
      sound_valid  <= 1'b0;
      primed_q     <= 1'b0;
      overrun      <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      if (bus_we) begin
        case (bus_addr)
          ADDR_FC_LO:    pend_q.fc_lo    <= bus_data;
          ADDR_FC_HI:    pend_q.fc_hi    <= bus_data;
          ADDR_RES_FILT: pend_q.res_filt <= bus_data;
          ADDR_MODE_VOL: pend_q.mode_vol <= bus_data;
          default: ;
        endcase
      end
      if (commit) begin
        act_q        <= pend_q;
        voice1_o     <= voice1_i;
        voice2_o     <= voice2_i;
        voice3_o     <= voice3_i;
        ext_o        <= ext_in_i;
        extfilter_en <= extfilt_i;
      end
      input_valid <= commit;
      sound_valid <= capture && primed_q;
      if (capture) begin
        sound_out <= sound_in;
        primed_q  <= 1'b1;
      end
      if (drop) begin
        overrun  <= 1'b1;
        drop_cnt <= (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1;
      end
    end
  end

  assign Fc_lo    = act_q.fc_lo;
  assign Fc_hi    = act_q.fc_hi;
  assign Res_Filt = act_q.res_filt;
  assign Mode_Vol = act_q.mode_vol;

endmodule

// File: tb/tb_sid_filter_seq.sv
// Randomized bench for sid_filter_seq against a cycle-timeline reference model.
module tb_sid_filter_seq;

  localparam int CLK_DIV = 32;
  localparam int FC      = 12;

  logic        clk = 1'b0;
  logic        rst, ext_tick, use_ext_tick, bus_we, extfilt_i;
  logic [4:0]  bus_addr;
  logic [7:0]  bus_data;
  logic [11:0] voice1_i, voice2_i, voice3_i, ext_in_i;
  logic [17:0] sound_in;
  logic [7:0]  Fc_lo, Fc_hi, Res_Filt, Mode_Vol, drop_cnt;
  logic [11:0] voice1_o, voice2_o, voice3_o, ext_o;
  logic        extfilter_en, input_valid, sound_valid, overrun;
  logic [17:0] sound_out;

  always #5 clk = ~clk;

  sid_filter_seq #(.CLK_DIV(CLK_DIV), .FILT_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .ext_tick(ext_tick), .use_ext_tick(use_ext_tick),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_data(bus_data),
    .voice1_i(voice1_i), .voice2_i(voice2_i), .voice3_i(voice3_i), .ext_in_i(ext_in_i),
    .extfilt_i(extfilt_i), .sound_in(sound_in),
    .Fc_lo(Fc_lo), .Fc_hi(Fc_hi), .Res_Filt(Res_Filt), .Mode_Vol(Mode_Vol),
    .voice1_o(voice1_o), .voice2_o(voice2_o), .voice3_o(voice3_o), .ext_o(ext_o),
    .extfilter_en(extfilter_en), .input_valid(input_valid), .sound_out(sound_out),
    .sound_valid(sound_valid), .overrun(overrun), .drop_cnt(drop_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a timeline of accepted samples rather than a state machine
  int          cyc = 0;
  int          div_cnt;
  bit          mode_q;
  int          last_acc;
  bit          primed;
  logic [7:0]  pend [4];
  logic [7:0]  act  [4];
  logic [11:0] m_voice [4];
  bit          m_ef, m_iv, m_sv, m_ov;
  logic [17:0] m_so;
  int          m_drop;
  int          last_iv = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    div_cnt  = 0;
    mode_q   = 1'b0;
    last_acc = -1000;
    primed   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pend[i] = '0; act[i] = '0; m_voice[i] = '0;
    end
    m_ef = 1'b0; m_iv = 1'b0; m_sv = 1'b0; m_ov = 1'b0;
    m_so = '0; m_drop = 0;
  endfunction

  function automatic void model_step();
    bit tick, idle;
    int since, idx;
    if (rst) begin
      model_reset();
    end else begin
      tick  = mode_q ? ext_tick : (div_cnt == CLK_DIV - 1);
      since = cyc - last_acc;
      // a pass occupies issue, capture and FILT_CYCLES-1 busy cycles after the accepting tick
      idle  = since >= FC + 2;
      m_iv  = idle && tick;
      m_sv  = (since == 2) && primed;
      if (since == 2) begin
        m_so   = sound_in;
        primed = 1'b1;
      end
      if (tick && !idle) begin
        m_ov = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      if (idle && tick) begin
        for (int i = 0; i < 4; i++) act[i] = pend[i];
        m_voice[0] = voice1_i; m_voice[1] = voice2_i;
        m_voice[2] = voice3_i; m_voice[3] = ext_in_i;
        m_ef     = extfilt_i;
        last_acc = cyc;
      end
      idx = int'(bus_addr) - 'h15;
      if (bus_we && idx >= 0 && idx < 4) pend[idx] = bus_data;
      div_cnt = (div_cnt + 1) % CLK_DIV;
      mode_q  = use_ext_tick;
    end
    cyc++;
  endfunction

  task automatic compare_all();
    chk("input_valid", 64'(input_valid), 64'(m_iv));
    chk("sound_valid", 64'(sound_valid), 64'(m_sv));
    chk("sound_out",   64'(sound_out),   64'(m_so));
    chk("overrun",     64'(overrun),     64'(m_ov));
    chk("drop_cnt",    64'(drop_cnt),    64'(m_drop));
    chk("regs", 64'({Fc_lo, Fc_hi, Res_Filt, Mode_Vol}), 64'({act[0], act[1], act[2], act[3]}));
    chk("voices", 64'({voice1_o, voice2_o, voice3_o, ext_o}),
        64'({m_voice[0], m_voice[1], m_voice[2], m_voice[3]}));
    chk("extfilter_en", 64'(extfilter_en), 64'(m_ef));
    if (input_valid) begin
      if (last_iv >= 0) chk("iv_spacing", 64'((cyc - last_iv) >= FC), 64'(1));
      last_iv = cyc;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit u,
                      input bit we, input logic [4:0] a, input logic [7:0] d);
    rst = r; ext_tick = e; use_ext_tick = u;
    bus_we = we; bus_addr = a; bus_data = d;
    voice1_i = 12'($urandom); voice2_i = 12'($urandom);
    voice3_i = 12'($urandom); ext_in_i = 12'($urandom);
    extfilt_i = 1'($urandom);
    sound_in  = 18'($urandom);
    if (r) last_iv = -1;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic rand_step(input bit r, input bit e, input bit u);
    step(r, e, u, ($urandom % 3) == 0, 5'(5'h13 + ($urandom % 8)), 8'($urandom));
  endtask

  initial begin
    bit u, fc_done, mv_done, reached;
    int fc_state;
    rst = 1'b1; ext_tick = 1'b0; use_ext_tick = 1'b0; bus_we = 1'b0;
    bus_addr = '0; bus_data = '0; voice1_i = '0; voice2_i = '0; voice3_i = '0;
    ext_in_i = '0; extfilt_i = 1'b0; sound_in = '0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 5'h0, 8'h0);

    // Internal tick; Fc_hi written two cycles before a tick, Mode_Vol on a commit cycle
    fc_done = 1'b0; mv_done = 1'b0; fc_state = 0;
    for (int i = 0; i < 200; i++) begin
      if (!fc_done && i > 40 && div_cnt == CLK_DIV - 3) begin
        step(1'b0, 1'($urandom), 1'b0, 1'b1, 5'h16, 8'h80);
        fc_done = 1'b1;
      end else if (fc_done && !mv_done && i > 80 && div_cnt == CLK_DIV - 1) begin
        step(1'b0, 1'($urandom), 1'b0, 1'b1, 5'h18, 8'h1F);
        mv_done = 1'b1;
      end else begin
        step(1'b0, 1'($urandom), 1'b0, 1'b0, 5'h0, 8'h0);
      end
      if (fc_done && fc_state == 0 && input_valid) begin
        chk("fc_hi_commit", 64'(Fc_hi), 64'(8'h80));
        fc_state = 1;
      end
    end

    // External tick every 8 cycles, 20 ticks
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'h0, 8'h0);
    for (int i = 0; i < 160; i++) rand_step(1'b0, (i % 8) == 0, 1'b1);
    chk("overrun_ext8", 64'(overrun), 64'(1));

    // Fully random mode switching, ticks and occasional reset
    u = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom % 50 == 0) u = ~u;
      rand_step(($urandom % 400) == 0, ($urandom % 6) == 0, u);
    end

    // Tick every cycle to drive drop_cnt into saturation
    step(1'b1, 1'b0, 1'b1, 1'b0, 5'h0, 8'h0);
    for (int i = 0; i < 400; i++) rand_step(1'b0, 1'b1, 1'b1);
    chk("drop_sat", 64'(drop_cnt), 64'(8'hFF));

    // Reset while busy, then a clean restart
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      rand_step(1'b0, 1'b0, 1'b0);
      reached = (cyc - last_acc) == 6;
    end
    chk("reach_busy", 64'(reached), 64'(1));
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'h0, 8'h0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    for (int i = 0; i < 120; i++) rand_step(1'b0, 1'($urandom), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
